// File: rtl/mvu_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_weight_loader
//  Description : Packs a narrow valid/ready beat stream into wide weight-bank
//                words and writes them to consecutive addresses of the MVU
//                weight bank, then pulses done once per load command.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvu_weight_loader #(
    parameter int BIN     = 64,
    parameter int BWBANKW = 4096,
    parameter int BWBANKA = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [BWBANKA-1:0] cmd_addr,
    input  logic [BWBANKA:0]   cmd_nwords,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BIN-1:0]     s_data,
    output logic               wrw_en,
    output logic [BWBANKA-1:0] wrw_addr,
    output logic [BWBANKW-1:0] wrw_word,
    output logic               busy,
    output logic               done
);

    localparam int NBEAT    = BWBANKW / BIN;
    localparam int c_BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(NBEAT - 1);
    localparam logic [BWBANKA:0]    c_ONE_WORD  = (BWBANKA + 1)'(1);

    // A word must be made of a whole number of beats.
    generate
        if ((BWBANKW % BIN) != 0 || BWBANKW < BIN) begin : g_param_check
            $error("mvu_weight_loader: BWBANKW must be an integer multiple of BIN");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [BWBANKA-1:0]   r_addr;
    logic [BWBANKA:0]     r_rem;
    logic [c_BEAT_W-1:0]  r_beat;
    logic [BWBANKW-1:0]   r_word;
    logic [BWBANKW-1:0]   w_word_ins;
    logic [BWBANKA-1:0]   r_wrw_addr;
    logic [BWBANKW-1:0]   r_wrw_word;
    logic                 w_last_beat;

    // Handshakes and pulses are masked by rst so an abort takes effect in
    // the very cycle rst is seen, before the state register has cleared.
    assign cmd_ready   = (r_state == IDLE)  && !rst;
    assign s_ready     = (r_state == FILL)  && !rst;
    assign wrw_en      = (r_state == WRITE) && !rst;
    assign done        = (r_state == DONE)  && !rst;
    assign busy        = (r_state != IDLE);
    assign wrw_addr    = r_wrw_addr;
    assign wrw_word    = r_wrw_word;
    assign w_last_beat = (r_beat == c_LAST_BEAT);

    // Current packing buffer with the incoming beat dropped into its slot.
    always_comb begin
        w_word_ins = r_word;
        w_word_ins[r_beat*BIN +: BIN] = s_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_next = (cmd_nwords == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (s_valid && w_last_beat) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_state_next = (r_rem == c_ONE_WORD) ? DONE : FILL;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Command latch, beat packing, and the held write-port registers.
    // The write-port registers are only loaded when a word completes, so
    // wrw_addr/wrw_word keep their last values between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_rem      <= '0;
            r_beat     <= '0;
            r_word     <= '0;
            r_wrw_addr <= '0;
            r_wrw_word <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr <= cmd_addr;
                        r_rem  <= cmd_nwords;
                        r_beat <= '0;
                    end
                end
                FILL: begin
                    if (s_valid) begin
                        r_word <= w_word_ins;
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_wrw_word <= w_word_ins;
                            r_wrw_addr <= r_addr;
                        end
                    end
                end
                WRITE: begin
                    // Address wraps naturally at the bank size.
                    r_addr <= r_addr + 1'b1;
                    r_rem  <= r_rem - 1'b1;
                    r_beat <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mvu_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvu_weight_loader
//  Description : Directed self-checking bench for mvu_weight_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvu_weight_loader;

    localparam int BIN     = 64;
    localparam int BWBANKW = 4096;
    localparam int BWBANKA = 9;
    localparam int NBEAT   = BWBANKW / BIN;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [BWBANKA-1:0] cmd_addr = '0;
    logic [BWBANKA:0]   cmd_nwords = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [BIN-1:0]     s_data = '0;
    logic               wrw_en;
    logic [BWBANKA-1:0] wrw_addr;
    logic [BWBANKW-1:0] wrw_word;
    logic               busy;
    logic               done;

    mvu_weight_loader #(
        .BIN     (BIN),
        .BWBANKW (BWBANKW),
        .BWBANKA (BWBANKA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_nwords (cmd_nwords),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .wrw_en     (wrw_en),
        .wrw_addr   (wrw_addr),
        .wrw_word   (wrw_word),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events and the bench's own expected words.
    logic [BWBANKA-1:0] wa_q[$];
    logic [BWBANKW-1:0] ww_q[$];
    logic [BWBANKW-1:0] exp_q[$];
    int                 wc_q[$];
    int                 dn_q[$];
    int busy_first = -1;
    int busy_last  = -1;
    int busy_cnt   = 0;
    int sr_viol    = 0;
    int cr_viol    = 0;

    int n_chk  = 0;
    int n_pass = 0;

    // Record write pulses, done pulses and handshake behaviour mid-cycle.
    always @(negedge clk) begin
        if (wrw_en === 1'b1) begin
            wa_q.push_back(wrw_addr);
            ww_q.push_back(wrw_word);
            wc_q.push_back(cyc);
        end
        if (done === 1'b1) dn_q.push_back(cyc);
        if (busy === 1'b1) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
        end
        if ((wrw_en === 1'b1 || done === 1'b1) && s_ready !== 1'b0) sr_viol++;
        if (busy === 1'b1 && cmd_ready !== 1'b0) cr_viol++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        wa_q.delete(); ww_q.delete(); wc_q.delete(); dn_q.delete(); exp_q.delete();
        busy_first = -1; busy_last = -1; busy_cnt = 0; sr_viol = 0; cr_viol = 0;
    endtask

    function automatic logic [63:0] mk(input logic [7:0] t, input int i);
        return {t, 8'(i / NBEAT), 16'h0, 32'(i % NBEAT)};
    endfunction

    task automatic do_cmd(input logic [BWBANKA-1:0] a, input logic [BWBANKA:0] n, output int acc);
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_nwords = n;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Offer nb beats with s_valid high pct% of the time; build expected words.
    task automatic feed(input int nb, input int pct, input logic [7:0] t);
        logic [BWBANKW-1:0] w;
        int  guard;
        bit  took;
        w = '0;
        for (int i = 0; i < nb; i++) begin
            guard = 0;
            took  = 1'b0;
            s_data = mk(t, i);
            while (!took) begin
                s_valid = ($urandom_range(99) < pct);
                took = s_valid && (s_ready === 1'b1);
                tick();
                guard++;
                if (guard > 1000) begin
                    check("feed_timeout", 64'(guard), 64'd0);
                    s_valid = 1'b0;
                    return;
                end
            end
            w[(i % NBEAT)*BIN +: BIN] = mk(t, i);
            if ((i % NBEAT) == NBEAT - 1) begin
                exp_q.push_back(w);
                w = '0;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int bound);
        int k;
        k = 0;
        while (dn_q.size() < n && k < bound) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check("done_count", 64'(dn_q.size()), 64'(n));
    endtask

    task automatic check_writes(input string tag, input int n, input int base);
        check({tag, "_nwr"}, 64'(wa_q.size()), 64'(n));
        check({tag, "_nexp"}, 64'(exp_q.size()), 64'(n));
        for (int i = 0; i < n && i < wa_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wa_q[i]), 64'((base + i) % (1 << BWBANKA)));
            for (int k = 0; k < NBEAT; k++) begin
                check($sformatf("%s_w%0d_b%0d", tag, i, k),
                      ww_q[i][k*BIN +: BIN], exp_q[i][k*BIN +: BIN]);
            end
        end
    endtask

    initial begin
        int acc;

        // T1: reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            cmd_valid  = 1'($urandom);
            s_valid    = 1'($urandom);
            s_data     = {$urandom, $urandom};
            cmd_addr   = BWBANKA'($urandom);
            cmd_nwords = (BWBANKA + 1)'($urandom);
            tick();
            check("t1_ctrl", {59'b0, cmd_ready, s_ready, wrw_en, busy, done}, 64'd0);
            check("t1_addr", 64'(wrw_addr), 64'd0);
            check("t1_word", wrw_word[63:0], 64'd0);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        s_valid = 1'b0;
        #1;
        check("t1_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        tick();

        // T2: single word at address 5, beats carry their own index.
        clr();
        do_cmd(9'd5, 10'd1, acc);
        feed(NBEAT, 100, 8'h00);
        wait_done(1, 20);
        check("t2_nwr", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() >= 1) begin
            check("t2_wr_cycle", 64'(wc_q[0] - acc), 64'd65);
            check("t2_addr", 64'(wa_q[0]), 64'd5);
            for (int k = 0; k < NBEAT; k++)
                check($sformatf("t2_b%0d", k), ww_q[0][k*BIN +: BIN], 64'(k));
        end
        if (dn_q.size() >= 1) check("t2_done_cycle", 64'(dn_q[0] - acc), 64'd66);
        check("t2_busy_first", 64'(busy_first - acc), 64'd1);
        check("t2_busy_last", 64'(busy_last - acc), 64'd66);
        check("t2_busy_cnt", 64'(busy_cnt), 64'd66);

        // T3: address wrap 510, 511, 0.
        clr();
        do_cmd(9'd510, 10'd3, acc);
        feed(3 * NBEAT, 100, 8'h33);
        wait_done(1, 20);
        check_writes("t3", 3, 510);
        if (dn_q.size() >= 1 && wc_q.size() >= 3) begin
            check("t3_done_after_last", 64'(dn_q[0] - wc_q[2]), 64'd1);
            check("t3_done_cycle", 64'(dn_q[0] - acc), 64'd196);
        end

        // T4: 50% valid backpressure over four words.
        clr();
        do_cmd(9'd100, 10'd4, acc);
        feed(4 * NBEAT, 50, 8'h44);
        wait_done(1, 400);
        check_writes("t4", 4, 100);
        check("t4_sready_wr_done", 64'(sr_viol), 64'd0);

        // T5a: zero-word command.
        clr();
        do_cmd(9'd7, 10'd0, acc);
        wait_done(1, 5);
        if (dn_q.size() >= 1) check("t5_done_cycle", 64'(dn_q[0] - acc), 64'd1);
        check("t5_nwr", 64'(wa_q.size()), 64'd0);

        // T5b: a competing command held during an active load is ignored.
        clr();
        do_cmd(9'd20, 10'd2, acc);
        cmd_valid  = 1'b1;
        cmd_addr   = 9'd300;
        cmd_nwords = 10'd1;
        feed(2 * NBEAT, 100, 8'h55);
        cmd_valid = 1'b0;
        wait_done(1, 20);
        check_writes("t5b", 2, 20);
        check("t5b_cmd_ready_busy", 64'(cr_viol), 64'd0);

        // T6: reset after 30 beats of word 0, then a clean load at 0.
        clr();
        do_cmd(9'd40, 10'd2, acc);
        feed(30, 100, 8'h60);
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = {$urandom, $urandom};
        tick();
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        repeat (80) tick();
        check("t6_nwr_abort", 64'(wa_q.size()), 64'd0);
        check("t6_ndone_abort", 64'(dn_q.size()), 64'd0);
        check("t6_idle", {62'b0, busy, cmd_ready}, 64'd1);
        clr();
        do_cmd(9'd0, 10'd1, acc);
        feed(NBEAT, 100, 8'h66);
        wait_done(1, 20);
        check_writes("t6", 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
